// File: rtl/regfile_dump_reader_pkg.sv
// Shared CPU register-file constants and the dump reader state encoding.
package regfile_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int HOLD_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_pacing.sv
// Generic pacing counter: clears on load, steps on count, flags a fixed terminal value.
module regfile_dump_reader_pacing #(
  parameter int             W        = 16,
  parameter logic [W-1:0]   TERMINAL = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic count_i,
  output logic terminal_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side register file dump sequencer: walks FIRST_REG..LAST_REG through an
// asynchronous read port, captures each value and presents it downstream.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int FIRST_REG   = 0,
  parameter int LAST_REG    = 31,
  parameter int HOLD_CYCLES = 0,
  parameter int SKIP_ZERO   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = REG_ADDR_W'(LAST_REG);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  =
    (HOLD_CYCLES == 0) ? '0 : HOLD_W'(HOLD_CYCLES - 1);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  hold_load;
  logic                  hold_count;
  logic                  hold_term;

  regfile_dump_reader_pacing #(
    .W        (HOLD_W),
    .TERMINAL (HOLD_LAST)
  ) u_hold_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (hold_load),
    .count_i    (hold_count),
    .terminal_o (hold_term)
  );

  // Handshake: out_valid is high for the whole PRESENT state and out_index/out_data
  // are frozen there; a transfer happens on any edge with out_valid && out_ready
  // and no abort. The address only advances on a transfer or a skip, never past LAST_REG.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    index_d    = index_q;
    data_d     = data_q;
    hold_load  = 1'b0;
    hold_count = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
            addr_d  = FIRST_ADDR;
          end
        end
        ST_FETCH: begin
          index_d = addr_q;
          data_d  = rd_data;
          if ((SKIP_ZERO != 0) && (rd_data == '0)) begin
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + REG_ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end else if (HOLD_CYCLES == 0) begin
            state_d = ST_PRESENT;
          end else begin
            state_d   = ST_HOLD;
            hold_load = 1'b1;
          end
        end
        ST_HOLD: begin
          hold_count = 1'b1;
          if (hold_term) begin
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + REG_ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign rd_addr   = addr_q;
  assign out_index = index_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == ST_PRESENT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
